// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RISC-V M-extension unit for the EX stage.
// Multiplies use shift-add on operand magnitudes. Divides use restoring
// division on magnitudes. Signs are fixed up when the result is written.
// Divide-by-zero and signed overflow finish one cycle after start.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0]      LAST = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [5:0]        cnt;
    logic              is_div;
    logic              is_rem;
    logic              low_half;
    logic              neg_q;
    logic              neg_r;
    // hi/lo form the product accumulator for multiplies, and the
    // remainder / dividend-shifting-into-quotient pair for divides
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] mcand;

    logic              in_div;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   special_res;

    logic [2*XLEN-1:0] prod_next;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              fits;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    assign busy      = (state == BUSY);
    assign done      = (state == DONE);
    assign stall_req = ((state == IDLE) && start) || (state == BUSY);

    // Decode the incoming request: signedness, magnitudes and early-out cases
    always_comb begin
        in_div   = op[2];
        a_signed = in_div ? ~op[0] : (op[1:0] != 2'b11);
        b_signed = in_div ? ~op[0] : ~op[1];
        a_neg    = a_signed & rs1_data[XLEN-1];
        b_neg    = b_signed & rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div_zero = in_div && (rs2_data == '0);
        overflow = in_div && ~op[0] && (rs1_data == SMIN) && (rs2_data == '1);
        if (div_zero)
            special_res = op[1] ? rs1_data : '1;
        else
            special_res = op[1] ? '0 : rs1_data;
    end

    // One iteration of shift-add or restoring divide, plus sign-corrected result
    always_comb begin
        prod_next = {hi, lo} + (opb[0] ? mcand : '0);
        shifted   = {hi, lo[XLEN-1]};
        diff      = shifted - {1'b0, opb};
        fits      = ~diff[XLEN];
        if (is_div) begin
            step_hi = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], fits};
        end else begin
            step_hi = prod_next[2*XLEN-1:XLEN];
            step_lo = prod_next[XLEN-1:0];
        end
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_r ? -step_hi : step_hi;
        if (is_div)
            final_res = is_rem ? rem_fix : quo_fix;
        else
            final_res = low_half ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    // Control FSM and datapath registers; flush beats start, reset beats all
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            is_rem   <= 1'b0;
            low_half <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            mcand    <= '0;
            result   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= op[2];
                        is_rem   <= op[1];
                        low_half <= (op[1:0] == 2'b00);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        hi       <= '0;
                        lo       <= in_div ? a_mag : '0;
                        opb      <= b_mag;
                        mcand    <= {{XLEN{1'b0}}, a_mag};
                        if (div_zero || overflow) begin
                            result <= special_res;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi    <= step_hi;
                    lo    <= step_lo;
                    mcand <= mcand << 1;
                    opb   <= is_div ? opb : (opb >> 1);
                    cnt   <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        result <= final_res;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected result and
// completion cycle; a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall_req;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    ex_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d required no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_cycle"}, cyc, e.at);
                chk({e.name, "_stall_in_done"}, {31'd0, stall_req}, 32'd0);
                chk({e.name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit push, output int t);
        @(posedge clk);
        #1;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        t        = cyc;
        if (push) sb.push_back('{res: exp, at: t + lat, name: name});
        #1;
        chk({name, "_stall_on_start"}, {31'd0, stall_req}, 32'd1);
    endtask

    task automatic release_start;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 3'b111;
        rs1_data = $urandom;
        rs2_data = $urandom;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in 100 cycles required done", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int t;
        issue(name, o, a, b, exp, lat, 1'b1, t);
        release_start();
        wait_done(name);
    endtask

    initial begin
        int t;
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_stall", {31'd0, stall_req}, 32'd0);

        // MUL 7 x -3 with latency profile
        issue("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, t);
        release_start();
        while (cyc < t + 1) @(negedge clk);
        @(negedge clk);
        chk("mul_busy_first", {31'd0, busy}, 32'd1);
        chk("mul_stall_busy", {31'd0, stall_req}, 32'd1);
        while (cyc < t + 32) @(negedge clk);
        chk("mul_busy_last", {31'd0, busy}, 32'd1);
        wait_done("mul_neg");

        run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulh_pos",    3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 33);
        run_op("mulhsu_neg",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("mulhu_small", 3'b011, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 33);
        run_op("mul_zero",    3'b000, 32'd0,         32'd5,         32'd0,         33);
        run_op("div_neg",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_neg",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu_big",    3'b101, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 33);
        run_op("div_negdiv",  3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_negdiv",  3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        run_op("remu",        3'b111, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu_allone", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
        run_op("divu_zero",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_zero",   3'b111, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("div_zero_s",  3'b100, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_zero_s",  3'b110, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 1);

        // Flush a DIV at T+10, then start a fresh op
        issue("div_flushed", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'd0, 0, 1'b0, t);
        release_start();
        while (cyc < t + 10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_stall", {31'd0, stall_req}, 32'd0);
        chk("result_hold", result, 32'hFFFF_FFF7);
        run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // Reset mid-MUL with start held high
        issue("mul_reset", 3'b000, 32'd123, 32'd456, 32'd0, 0, 1'b0, t);
        while (cyc < t + 20) begin
            @(posedge clk);
            #1;
            rs1_data = $urandom;
            rs2_data = $urandom;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        chk("midreset_stall", {31'd0, stall_req}, 32'd1);
        start = 1'b0;

        // Start held through BUSY and DONE must not be re-accepted
        issue("mul_hold", 3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 33, 1'b1, t);
        while (cyc < t + 33) begin
            @(posedge clk);
            #1;
            rs1_data = $urandom;
            rs2_data = $urandom;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("hold_no_reaccept_busy", {31'd0, busy}, 32'd0);
        chk("hold_no_reaccept_done", {31'd0, done}, 32'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; the iteration count equals XLEN.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request from EX stage: valid_id_ex AND M-extension op decoded.
REQ-005 SHALL have port op  input  3  funct3_for_branch field: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data  input  XLEN  operand A, forwarded value.
REQ-007 SHALL have port rs2_data  input  XLEN  operand B, forwarded value.
REQ-008 SHALL have port flush  input  1  abort the in-flight operation.
REQ-009 SHALL have port stall_req  output  1  hold request driven to the upstream stall inputs of the IF/ID and ID/EX registers.
REQ-010 SHALL have port busy  output  1  high while state is BUSY.
REQ-011 SHALL have port done  output  1  result valid, one-cycle pulse.
REQ-012 SHALL have port result  output  XLEN  operation result, valid when done=1.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL latch op, rs1_data and rs2_data on the edge where the state is IDLE and start=1, ignoring the operand inputs afterwards.
REQ-015 SHALL ignore start in the BUSY and DONE states.
REQ-016 SHALL drive stall_req = (IDLE and start) or BUSY as a combinational output, and drive it 0 in DONE so the pipeline advances with the result.
REQ-017 For the normal path, with start accepted at edge T, SHALL hold busy=1 in cycles T+1..T+XLEN, assert done=1 in cycle T+XLEN+1 only, and return to IDLE at the next edge.
REQ-018 SHALL hold a 6-bit iteration counter that counts 0..XLEN-1 in BUSY; BUSY goes to DONE when the counter reaches XLEN-1.
REQ-019 SHALL compute multiplies by shift-add on operand magnitudes into a 2*XLEN product, then negate the product when the sign-corrected operands differ in sign.
REQ-020 Multiply operand signedness: MUL and MULH treat A and B as signed, MULHSU treats A as signed and B as unsigned, MULHU treats both as unsigned.
REQ-021 Multiply result selection: MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
REQ-022 SHALL compute divides by restoring division on magnitudes; DIV/REM are signed, DIVU/REMU unsigned.
REQ-023 For signed divides, quotient sign = sign(A) XOR sign(B) and remainder sign = sign(A).
REQ-024 Divide by zero SHALL go IDLE to DONE directly (done at T+1): quotient = all ones, remainder = A.
REQ-025 Signed overflow (A = -2^(XLEN-1), B = -1, op DIV/REM) SHALL go IDLE to DONE directly: quotient = A, remainder = 0.
REQ-026 The result register SHALL be written only on the transition into DONE; result holds its value while IDLE.
REQ-027 flush=1 SHALL force the state to IDLE at the next edge from any state with no done pulse; flush has priority over start.
REQ-028 When flush and start are both 1 in IDLE, the start SHALL be dropped.
REQ-029 All arithmetic SHALL be modulo 2^XLEN (2^(2*XLEN) for the product), with no exceptions or traps.

Reset
REQ-030 On reset=1 at an edge, the state SHALL go to IDLE, the counter and all internal registers to 0, and result to 0.
REQ-031 After reset, busy=0, done=0, and stall_req follows start per REQ-016.
REQ-032 Reset mid-operation SHALL abandon the operation immediately with no done pulse.

Verification
REQ-033 MUL 7 x -3: start at T -> busy T+1..T+32, done at T+33 with result 0xFFFFFFEB, stall_req 0 at T+33.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 0x80000000 / 3 -> 0x2AAAAAAA; latency 33 cycles.
REQ-036 DIVU 5 / 0 -> done at T+1, result 0xFFFFFFFF; REMU 5 % 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000 at T+1.
REQ-037 flush at T+10 of a DIV -> IDLE at T+11, no done pulse, stall_req 0; a new start at T+12 completes normally.
REQ-038 reset at T+20 of a MUL -> IDLE, result 0, no done pulse; start held during BUSY is not re-accepted until IDLE.
